// File: rtl/binary_div_16_seq_bi_if.sv
// -----------------------------------------------------------------------------
// binary_div_16_seq_bi_if
// Handshake and operand/result bundle for the sequential signed divider.
//   en       : clock enable; when low the divider holds every register
//   start    : request, sampled only while the divider is idle
//   A / B    : signed dividend (DW) / signed divisor (VW)
//   Q / R    : signed quotient (DW) / signed remainder (VW)
//   busy     : operation in progress
//   done     : one-cycle completion pulse
//   div_zero : last result had a zero divisor
//   ovf      : last result overflowed (most-negative dividend / -1)
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface binary_div_16_seq_bi_if #(
  parameter int DW = 31,
  parameter int VW = 16
);
  logic                 en;
  logic                 start;
  logic signed [DW-1:0] A;
  logic signed [VW-1:0] B;
  logic signed [DW-1:0] Q;
  logic signed [VW-1:0] R;
  logic                 busy;
  logic                 done;
  logic                 div_zero;
  logic                 ovf;

  modport master (
    output en, start, A, B,
    input  Q, R, busy, done, div_zero, ovf
  );

  modport slave (
    input  en, start, A, B,
    output Q, R, busy, done, div_zero, ovf
  );
endinterface

// File: rtl/binary_div_16_seq_bi.sv
// -----------------------------------------------------------------------------
// binary_div_16_seq_bi
// Sequential signed radix-2 restoring divider (inverse of the 16-bit signed
// multiplier). One quotient bit per enabled clock; result truncates toward
// zero and the remainder carries the sign of the dividend.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : binary_div_16_seq_bi_if.slave (en/start/A/B in, Q/R/flags out)
// Latency: done is high in the cycle after the (DW+2)-th enabled edge that
// follows the accepting edge, for every operand including the special cases.
// -----------------------------------------------------------------------------
module binary_div_16_seq_bi #(
  parameter int DW = 31,
  parameter int VW = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  binary_div_16_seq_bi_if.slave      bus
);

  localparam int CW = $clog2(DW + 1);
  localparam logic signed [DW-1:0] A_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  // Magnitudes are held unsigned so that -2^(N-1) converts without loss.
  function automatic logic [DW-1:0] abs_dvd(input logic signed [DW-1:0] v);
    logic [DW-1:0] u;
    u = v;
    return v[DW-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [VW-1:0] abs_div(input logic signed [VW-1:0] v);
    logic [VW-1:0] u;
    u = v;
    return v[VW-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic signed [DW-1:0] sign_q(input logic [DW-1:0] mag,
                                                  input logic        neg);
    return neg ? $signed(~mag + 1'b1) : $signed(mag);
  endfunction

  function automatic logic signed [VW-1:0] sign_r(input logic [VW-1:0] mag,
                                                  input logic        neg);
    return neg ? $signed(~mag + 1'b1) : $signed(mag);
  endfunction

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [DW-1:0]        r_dvd;     // dividend magnitude, quotient bits shift in at LSB
  logic [VW-1:0]        r_rem;     // partial remainder magnitude (< |B|)
  logic [VW-1:0]        r_div;     // divisor magnitude
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_zero;
  logic                 r_ovf_c;
  logic [VW-1:0]        r_a_lo;    // remainder returned on divide-by-zero
  logic signed [DW-1:0] r_q;
  logic signed [VW-1:0] r_r;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_div_zero;
  logic                 r_ovf;

  logic [VW:0]          w_shift;
  logic                 w_ge;
  logic [VW-1:0]        w_diff;
  logic [VW-1:0]        w_rem_nxt;

  // Restoring step: the shifted remainder is VW+1 bits wide for the compare;
  // after a successful subtract the result is below |B| and fits VW bits.
  assign w_shift   = {r_rem, r_dvd[DW-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_diff    = w_shift[VW-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[VW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf_c    <= 1'b0;
      r_a_lo     <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (bus.en) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_dvd   <= abs_dvd(bus.A);
            r_div   <= abs_div(bus.B);
            r_rem   <= '0;
            r_neg_q <= bus.A[DW-1] ^ bus.B[VW-1];
            r_neg_r <= bus.A[DW-1];
            r_zero  <= (bus.B == '0);
            r_ovf_c <= (bus.A == A_MIN) && (bus.B == '1);
            r_a_lo  <= bus.A[VW-1:0];
            r_cnt   <= CW'(DW);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[DW-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          // Special cases override the datapath result but keep the latency.
          if (r_zero) begin
            r_q        <= '1;
            r_r        <= $signed(r_a_lo);
            r_div_zero <= 1'b1;
            r_ovf      <= 1'b0;
          end else if (r_ovf_c) begin
            r_q        <= A_MIN;
            r_r        <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b1;
          end else begin
            r_q        <= sign_q(r_dvd, r_neg_q);
            r_r        <= sign_r(r_rem, r_neg_r);
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Q        = r_q;
  assign bus.R        = r_r;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_binary_div_16_seq_bi.sv
// -----------------------------------------------------------------------------
// tb_binary_div_16_seq_bi
// Scoreboard bench for the sequential signed divider. The driver pushes the
// expected result (from plain signed arithmetic) with the enabled-edge count
// at which done must be seen; a monitor pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_binary_div_16_seq_bi;
  localparam int DW = 31;
  localparam int VW = 16;
  localparam logic signed [DW-1:0] AMIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct {
    logic signed [DW-1:0] a;
    logic signed [VW-1:0] b;
    logic signed [DW-1:0] q;
    logic signed [VW-1:0] r;
    logic                 dz;
    logic                 ov;
    int                   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  binary_div_16_seq_bi_if #(.DW(DW), .VW(VW)) bus ();
  binary_div_16_seq_bi #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   en_edges = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: spec-level signed division with the two special cases.
  function automatic exp_t model(input logic signed [DW-1:0] a,
                                 input logic signed [VW-1:0] b);
    exp_t   e;
    longint la;
    longint lb;
    longint lq;
    longint lr;
    la   = a;
    lb   = b;
    e.a  = a;
    e.b  = b;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.due = 0;
    if (lb == 0) begin
      e.dz = 1'b1;
      e.q  = '1;
      e.r  = a[VW-1:0];
    end else if (la == -(longint'(1) <<< (DW-1)) && lb == -1) begin
      e.ov = 1'b1;
      e.q  = a;
      e.r  = '0;
    end else begin
      lq  = la / lb;
      lr  = la % lb;
      e.q = lq[DW-1:0];
      e.r = lr[VW-1:0];
    end
    return e;
  endfunction

  // Enabled-edge counter: latency is defined in enabled edges.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && bus.en) en_edges++;
    end
  end

  // Monitor
  initial begin
    exp_t   e;
    int     last_done;
    longint inv;
    longint ar;
    longint ab;
    last_done = -10;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done && en_edges != last_done) begin
        last_done = en_edges;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done at edge %0d, expected none", en_edges);
        end else begin
          e = sb.pop_front();
          check("Q", bus.Q, e.q);
          check("R", bus.R, e.r);
          check("div_zero", bus.div_zero, e.dz);
          check("ovf", bus.ovf, e.ov);
          check("latency_edge", en_edges, e.due);
          check("busy_at_done", bus.busy, 1'b0);
          if (!e.dz && !e.ov) begin
            inv = longint'(bus.Q) * longint'(bus.B === bus.B ? e.b : e.b) + longint'(bus.R);
            check("invariant", inv, e.a);
            ar = bus.R;
            ab = e.b;
            if (ar < 0) ar = -ar;
            if (ab < 0) ab = -ab;
            check("rem_lt_div", (ar < ab) ? 1 : 0, 1);
          end
        end
      end
    end
  end

  task automatic issue(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b,
                       input bit jitter);
    int          guard;
    exp_t        e;
    logic [31:0] rnd;
    guard = 0;
    @(negedge clk);
    bus.en = 1'b1;
    while (bus.busy !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=%0d, expected 0", bus.busy);
    end
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    e         = model(a, b);
    e.due     = en_edges + DW + 3;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    rnd   = $urandom;
    bus.A = rnd[DW-1:0];
    rnd   = $urandom;
    bus.B = rnd[VW-1:0];
    if (jitter) begin
      for (int i = 0; i < 20; i++) begin
        bus.en = 1'(($urandom_range(0, 1)));
        @(negedge clk);
      end
    end
    bus.en = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_Q"}, bus.Q, 0);
    check({tag, "_R"}, bus.R, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_div_zero"}, bus.div_zero, 0);
    check({tag, "_ovf"}, bus.ovf, 0);
  endtask

  initial begin
    logic [31:0]          rnd;
    logic signed [DW-1:0] ra;
    logic signed [VW-1:0] rb;
    int                   guard;
    bus.en    = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(31'sd1073709056, -16'sd32767, 1'b0);
    issue(31'sd7, -16'sd2, 1'b0);
    issue(-31'sd7, 16'sd2, 1'b0);
    issue(-31'sd7, -16'sd2, 1'b0);
    issue(31'sd12345, 16'sd0, 1'b0);
    issue(31'sd100, 16'sd7, 1'b0);
    issue(AMIN, -16'sd1, 1'b0);
    issue(AMIN, 16'sd32767, 1'b0);

    // en held low for 5 cycles mid-CALC while start is toggled
    issue(31'sd1000000, 16'sd123, 1'b0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.en    = 1'b0;
      bus.start = ~bus.start;
      @(negedge clk);
    end
    bus.en    = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;

    // Asynchronous reset in the middle of CALC
    issue(-31'sd99999, 16'sd321, 1'b0);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("abort_idle_busy", bus.busy, 0);
    issue(-31'sd99999, 16'sd321, 1'b0);

    // Randomized operands with random enable gaps
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom;
      ra  = rnd[DW-1:0];
      rnd = $urandom;
      rb  = rnd[VW-1:0];
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin rb = '1; if (rnd[0]) ra = AMIN; end
        2: begin rb = 16'($urandom_range(1, 10)); if (rnd[1]) rb = -rb; end
        3: ra = AMIN;
        default: ;
      endcase
      issue(ra, rb, n[0]);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d outstanding results, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/binary_div_16_seq_bi.md
Name: binary_div_16_seq_bi

Overview:
- Sequential signed radix-2 restoring divider; the inverse of the team's 16-bit signed multiplier.
- Takes a 31-bit signed product-width dividend and a 16-bit signed divisor. Returns the signed quotient and remainder.
- Used to recover a multiplier operand from a product, and as a general arithmetic unit in the same datapath.
- Start/busy/done handshake; one quotient bit per enabled clock.

Parameters:
- DW, 31, dividend and quotient width (signed, two's complement)
- VW, 16, divisor and remainder width (signed, two's complement)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  clock enable; when low, all state and outputs hold
- start  input  1  request; sampled only in IDLE with en=1
- A  input  DW  signed dividend; captured on the accepting edge
- B  input  VW  signed divisor; captured on the accepting edge
- Q  output  DW  signed quotient
- R  output  VW  signed remainder
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; Q/R/flags valid
- div_zero  output  1  last result had B=0
- ovf  output  1  last result overflowed (A=-2^(DW-1), B=-1)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; Q=0, R=0, busy=0, done=0, div_zero=0, ovf=0.
  - Internal registers and counter cleared.
  - Takes effect immediately, including mid-operation; the aborted result is never presented.
- en=0: no register changes (state, counter, outputs, done included). The operation resumes when en returns high. Latency counts enabled edges only.
- FSM states:
  - IDLE -> CALC on enabled edge with start=1.
    - Capture |A|, |B|, sign_q = A[DW-1]^B[VW-1], sign_r = A[DW-1].
    - Capture zero/ovf conditions; counter=DW; busy<=1; done<=0.
    - start is ignored while busy=1.
  - CALC: each enabled edge performs one restoring step:
    - Shift the partial remainder (VW+1 bits, unsigned magnitude) left and take the next dividend MSB.
    - If it is >= |B|, subtract |B| and set the quotient bit to 1, else set it to 0.
    - Counter decrements; at counter=1 -> FIX.
  - FIX: one enabled edge.
    - Apply signs: Q = sign_q ? -mag_q : mag_q; R = sign_r ? -mag_r : mag_r.
    - Apply the special cases below, then go to DONE.
  - DONE: one enabled edge.
    - done=1 for exactly this cycle; busy=0 in this cycle; return to IDLE.
    - A start sampled during DONE is ignored; start must be presented again in IDLE.
- Latency: done is high in the cycle following the (DW+2)-th enabled rising edge after the accepting edge (33 for DW=31). Latency is constant for all operands, special cases included.
- Q, R, div_zero and ovf update only at FIX and hold until the next FIX or reset.
- Arithmetic:
  - Truncation toward zero; the remainder takes the sign of the dividend (matches Verilog signed / and %).
  - Invariant: A = Q*B + R and |R| < |B|.
- B=0: div_zero=1, Q = all ones (-1), R = A[VW-1:0], ovf=0.
- A=-2^(DW-1), B=-1: ovf=1, Q=-2^(DW-1) (wrapped), R=0, div_zero=0.
- Magnitude of -2^(DW-1) (and -2^(VW-1)) is represented unsigned, without loss.
- A change on A or B after the accepting edge has no effect.

Test Plan:
- Reset, en=1, A=1073709056, B=-32767, start pulse -> done after 33 enabled edges; Q=-32768, R=0, div_zero=0, ovf=0.
- Sign combinations, each case checked against the A=Q*B+R invariant:
  - A=7, B=-2 -> Q=-3, R=1.
  - A=-7, B=2 -> Q=-3, R=-1.
  - A=-7, B=-2 -> Q=3, R=-1.
- A=12345, B=0 -> done at the same latency; div_zero=1, Q=-1, R=12345. A following A=100, B=7 -> div_zero=0, Q=14, R=2.
- A=-1073741824, B=-1 -> ovf=1, Q=-1073741824, R=0. Then A=-1073741824, B=32767 -> Q=-32769, R=-1, ovf=0.
- en low for 5 cycles mid-CALC, with start toggled while busy=1:
  - done arrives 5 cycles later than nominal; result correct.
  - The extra start is ignored.
  - done lasts exactly one cycle.
- rst_n pulsed low at CALC cycle 10 -> all outputs 0 immediately, no done pulse. A fresh start after release completes normally.
